// File: rtl/ula_out_ctrl.sv
`default_nettype none
// ula_out_ctrl: registers ALU result/flags into ALUOut and traps signed overflow
// into a held exception request carrying the faulting PC and an event count.
module ula_out_ctrl #(
  parameter int         DATA_W   = 32,
  parameter logic [7:0] OVF_CODE = 8'h0C,
  parameter int         CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ula_valid,
  input  logic [DATA_W-1:0] ula_result,
  input  logic              ula_overflow,
  input  logic              ula_zero,
  input  logic              ula_lt,
  input  logic              ovf_enable,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              aluout_rd,
  input  logic              exc_ack,
  output logic [DATA_W-1:0] aluout,
  output logic              zero_q,
  output logic              lt_q,
  output logic              out_valid,
  output logic              exc_req,
  output logic [7:0]        exc_cause,
  output logic [DATA_W-1:0] epc,
  output logic [CNT_W-1:0]  ovf_count
);

  localparam logic [DATA_W-1:0] c_INSTR_BYTES = DATA_W'(4);
  localparam logic [CNT_W-1:0]  c_CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_EXC  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic              w_trap, w_capture;
  logic              w_do_capture, w_do_trap, w_do_consume, w_do_ack;
  logic [DATA_W-1:0] r_aluout, r_epc;
  logic              r_zero, r_lt, r_out_valid, r_exc_req;
  logic [7:0]        r_exc_cause;
  logic [CNT_W-1:0]  r_ovf_count;

  assign w_trap    = ula_valid & ovf_enable & ula_overflow;
  assign w_capture = ula_valid & ~w_trap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_do_capture = 1'b0;
    w_do_trap    = 1'b0;
    w_do_consume = 1'b0;
    w_do_ack     = 1'b0;
    case (r_state)
      S_IDLE, S_HOLD: begin
        // A new result takes priority over a consumer read in the same cycle.
        if (w_capture) begin
          w_do_capture = 1'b1;
          w_state_nxt  = S_HOLD;
        end else if (w_trap) begin
          w_do_trap   = 1'b1;
          w_state_nxt = S_EXC;
        end else if (aluout_rd && (r_state == S_HOLD)) begin
          w_do_consume = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      S_EXC: begin
        if (exc_ack) begin
          w_do_ack    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_aluout    <= '0;
      r_zero      <= 1'b0;
      r_lt        <= 1'b0;
      r_out_valid <= 1'b0;
      r_exc_req   <= 1'b0;
      r_exc_cause <= 8'h00;
      r_epc       <= '0;
      r_ovf_count <= '0;
    end else begin
      if (w_do_capture) begin
        r_aluout    <= ula_result;
        r_zero      <= ula_zero;
        r_lt        <= ula_lt;
        r_out_valid <= 1'b1;
      end
      if (w_do_consume) r_out_valid <= 1'b0;
      if (w_do_trap) begin
        r_out_valid <= 1'b0;
        r_exc_req   <= 1'b1;
        r_exc_cause <= OVF_CODE;
        // pc_in is already PC+4 of the faulting instruction.
        r_epc       <= pc_in - c_INSTR_BYTES;
        if (r_ovf_count != '1) r_ovf_count <= r_ovf_count + c_CNT_ONE;
      end
      if (w_do_ack) begin
        r_exc_req   <= 1'b0;
        r_exc_cause <= 8'h00;
      end
    end
  end

  assign aluout    = r_aluout;
  assign zero_q    = r_zero;
  assign lt_q      = r_lt;
  assign out_valid = r_out_valid;
  assign exc_req   = r_exc_req;
  assign exc_cause = r_exc_cause;
  assign epc       = r_epc;
  assign ovf_count = r_ovf_count;

endmodule
`default_nettype wire
